snoop_bus_ctrl: RTL and testbench
=================================

SNOOP_BUS_CTRL -- requirements
Module: snoop_bus_ctrl

Interface
REQ-001 SHALL have parameter NCORE, default 2, number of caches on the snoop bus (legal 2..8).
REQ-002 SHALL have parameter BLK_WORDS, default 2, words per block written back (legal 1..8).
REQ-003 SHALL have parameter AW, default 32, snoop address width.
REQ-004 SHALL have ports: CLK  in  1  clock; nRST  in  1  asynchronous active-low reset.
REQ-005 SHALL have cctrans  in  NCORE  per-cache coherence request.
REQ-006 SHALL have ccwrite  in  NCORE  per-cache write intent (request for modify).
REQ-007 SHALL have daddr  in  NCORE*AW  per-cache request address; cache i occupies bits [i*AW +: AW].
REQ-008 SHALL have snoop_done  in  NCORE  snooped cache finished its tag lookup.
REQ-009 SHALL have snoop_dirty  in  NCORE  snooped cache holds the block modified; valid with snoop_done.
REQ-010 SHALL have dwait  in  NCORE  per-cache memory-side wait.
REQ-011 SHALL have ccwait  out  NCORE  stall to cache.
REQ-012 SHALL have ccinv  out  NCORE  invalidate to snooped cache.
REQ-013 SHALL have ccsnoopaddr  out  AW  broadcast snoop address.
REQ-014 SHALL have grant  out  NCORE  one-hot owner of the current transaction.
REQ-015 SHALL have wb_src  out  NCORE  one-hot cache currently writing back.
REQ-016 SHALL have xfer_done  out  1  one-cycle pulse at transaction end.
REQ-017 SHALL have snoop_err  out  1  one-cycle timeout pulse; present only with SNOOP_TIMEOUT_EN.

Function
REQ-018 SHALL implement states IDLE, SNOOP, WB, DONE.
REQ-019 In IDLE, if any cctrans is high, SHALL grant by round-robin starting one index above the last granted cache (cache 0 first after reset) and go to SNOOP next cycle.
REQ-020 On grant SHALL register ccsnoopaddr <= daddr[owner], grant <= one-hot owner, ccinv <= ~grant when ccwrite[owner] else 0.
REQ-021 In SNOOP and WB, SHALL drive ccwait high for every non-owner; owner's ccwait stays low.
REQ-022 In SNOOP, SHALL accumulate a sticky done mask of snoop_done over non-owners; owner's snoop_done is ignored.
REQ-023 SHALL leave SNOOP when the done mask covers all non-owners: to WB if any non-owner reported snoop_dirty (lowest index chosen, wb_src set), else to DONE.
REQ-024 More than one dirty responder is a protocol error; only the lowest-index one SHALL be written back.
REQ-025 In WB, a 3-bit word counter SHALL increment on each cycle with dwait[wb_src] low; after BLK_WORDS such cycles go to DONE.
REQ-026 In DONE, SHALL pulse xfer_done, clear grant, wb_src, ccinv and ccwait, and return to IDLE; minimum transaction is 3 cycles (IDLE->SNOOP->DONE).
REQ-027 New cctrans arriving outside IDLE SHALL be ignored until IDLE; requesters hold cctrans until xfer_done.
REQ-028 ccsnoopaddr SHALL hold its last value outside transactions.

Reset
REQ-029 On nRST low, asynchronously: state IDLE; ccwait, ccinv, grant, wb_src, xfer_done, snoop_err, ccsnoopaddr all 0; round-robin pointer selects cache 0; counters 0.
REQ-030 Reset mid-transaction SHALL abandon it without a xfer_done pulse.

Configuration
REQ-031 With SNOOP_TIMEOUT_EN defined, an 8-bit counter SHALL run in SNOOP; at 255 cycles without full done mask, SHALL pulse snoop_err, skip WB, go to DONE.
REQ-032 Without SNOOP_TIMEOUT_EN, snoop_err SHALL be absent and SNOOP waits indefinitely.

Verification
REQ-033 NCORE=2: cctrans[0]=1, ccwrite[0]=0, daddr0=0x100, snoop_done[1] at cycle 2, clean -> ccsnoopaddr=0x100, ccwait=2'b10, ccinv=0, xfer_done 3 cycles after request.
REQ-034 NCORE=2: cctrans[1] with ccwrite[1]=1, cache 0 dirty, BLK_WORDS=2, dwait[0] low 1 of 2 cycles -> ccinv=2'b01, wb_src=2'b01, WB lasts 4 cycles, then xfer_done.
REQ-035 NCORE=4: cctrans=4'b1111 held -> grants in order 0,1,2,3,0, each ending with xfer_done.
REQ-036 NCORE=4: caches 1 and 3 report dirty -> wb_src=4'b0010.
REQ-037 With SNOOP_TIMEOUT_EN: snoop_done never asserted -> snoop_err pulse after 255 SNOOP cycles, then xfer_done; nRST low in WB -> all outputs 0 immediately.

Source files
------------

// File: rtl/snoop_bus_ctrl.sv
// snoop_bus_ctrl: snoop-bus arbiter and transaction sequencer for NCORE caches.
// One cache at a time owns the bus. Its address is broadcast, every other cache
// looks the block up, and at most one dirty holder writes the block back before
// the transaction closes with a one-cycle xfer_done pulse.
// Optional feature: define SNOOP_TIMEOUT_EN to bound the snoop phase to 255
// cycles and add the snoop_err output.
//
// Handshake: a requester raises cctrans[i] and holds it until it sees xfer_done.
// Requests that arrive outside IDLE are only considered once the FSM is back in
// IDLE. snoop_dirty[i] is only meaningful in a cycle where snoop_done[i] is high.
// fsm_state exposes the FSM state (IDLE=0, SNOOP=1, WB=2, DONE=3).
module snoop_bus_ctrl #(
  parameter int NCORE     = 2,
  parameter int BLK_WORDS = 2,
  parameter int AW        = 32
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [NCORE-1:0]    cctrans,
  input  logic [NCORE-1:0]    ccwrite,
  input  logic [NCORE*AW-1:0] daddr,
  input  logic [NCORE-1:0]    snoop_done,
  input  logic [NCORE-1:0]    snoop_dirty,
  input  logic [NCORE-1:0]    dwait,
  output logic [NCORE-1:0]    ccwait,
  output logic [NCORE-1:0]    ccinv,
  output logic [AW-1:0]       ccsnoopaddr,
  output logic [NCORE-1:0]    grant,
  output logic [NCORE-1:0]    wb_src,
  output logic                xfer_done,
`ifdef SNOOP_TIMEOUT_EN
  output logic                snoop_err,
`endif
  output logic [1:0]          fsm_state
);

  localparam int IW = $clog2(NCORE);

  typedef enum logic [1:0] {IDLE = 2'd0, SNOOP = 2'd1, WB = 2'd2, DONE = 2'd3} state_t;

  state_t           state;
  logic [IW-1:0]    rr_ptr;      // first index searched at the next arbitration
  logic [NCORE-1:0] done_mask;   // sticky: non-owners that finished lookup
  logic [NCORE-1:0] dirty_mask;  // sticky: non-owners that reported dirty
  logic [2:0]       word_cnt;
`ifdef SNOOP_TIMEOUT_EN
  logic [7:0]       tmo_cnt;
`endif

  logic             pick_found;
  logic [IW-1:0]    pick_idx;
  logic [IW:0]      cand;
  logic [NCORE-1:0] pick_oh;
  logic [IW-1:0]    next_ptr;
  logic [NCORE-1:0] done_acc;
  logic [NCORE-1:0] dirty_acc;
  logic [NCORE-1:0] dirty_oh;
  logic             all_done;
  logic             wb_beat;
  logic             last_word;

  assign fsm_state = state;

  // Round-robin search starting at rr_ptr, wrapping modulo NCORE.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < NCORE; k++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NCORE)) cand = cand - (IW+1)'(NCORE);
      if (!pick_found && cctrans[cand[IW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IW-1:0];
      end
    end
  end

  assign pick_oh  = {{(NCORE-1){1'b0}}, 1'b1} << pick_idx;
  assign next_ptr = (pick_idx == IW'(NCORE-1)) ? '0 : pick_idx + 1'b1;

  // Current-cycle responses are folded in so a snoop can finish in one cycle;
  // the owner's own snoop lines are masked off by grant.
  assign done_acc  = done_mask | (snoop_done & ~grant);
  assign dirty_acc = dirty_mask | (snoop_dirty & snoop_done & ~grant);
  assign all_done  = &(done_acc | grant);
  assign dirty_oh  = dirty_acc & (~dirty_acc + 1'b1);  // lowest dirty responder
  assign wb_beat   = |(wb_src & ~dwait);
  assign last_word = (word_cnt == 3'(BLK_WORDS-1));

  // Transaction FSM with all outputs registered.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      done_mask   <= '0;
      dirty_mask  <= '0;
      word_cnt    <= '0;
      ccwait      <= '0;
      ccinv       <= '0;
      ccsnoopaddr <= '0;
      grant       <= '0;
      wb_src      <= '0;
      xfer_done   <= 1'b0;
`ifdef SNOOP_TIMEOUT_EN
      tmo_cnt     <= '0;
      snoop_err   <= 1'b0;
`endif
    end else begin
      xfer_done <= 1'b0;
`ifdef SNOOP_TIMEOUT_EN
      snoop_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pick_found) begin
            state       <= SNOOP;
            grant       <= pick_oh;
            ccwait      <= ~pick_oh;
            ccinv       <= ccwrite[pick_idx] ? ~pick_oh : '0;
            ccsnoopaddr <= daddr[pick_idx*AW +: AW];
            rr_ptr      <= next_ptr;
            done_mask   <= '0;
            dirty_mask  <= '0;
            word_cnt    <= '0;
`ifdef SNOOP_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
          end
        end
        SNOOP: begin
          done_mask  <= done_acc;
          dirty_mask <= dirty_acc;
          if (all_done) begin
            if (|dirty_acc) begin
              state  <= WB;
              wb_src <= dirty_oh;
            end else begin
              state     <= DONE;
              xfer_done <= 1'b1;
              grant     <= '0;
              ccinv     <= '0;
              ccwait    <= '0;
            end
          end
`ifdef SNOOP_TIMEOUT_EN
          else if (tmo_cnt == 8'd254) begin
            state     <= DONE;
            xfer_done <= 1'b1;
            snoop_err <= 1'b1;
            grant     <= '0;
            ccinv     <= '0;
            ccwait    <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
`endif
        end
        WB: begin
          if (wb_beat) begin
            if (last_word) begin
              state     <= DONE;
              xfer_done <= 1'b1;
              grant     <= '0;
              wb_src    <= '0;
              ccinv     <= '0;
              ccwait    <= '0;
            end else begin
              word_cnt <= word_cnt + 3'd1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// tb_snoop_bus_ctrl: directed bench for snoop_bus_ctrl with a 2-cache and a
// 4-cache instance sharing clock and reset. Grants of the 4-cache instance are
// checked against an expected queue by a monitor.
module tb_snoop_bus_ctrl;

  localparam logic [1:0] S_IDLE = 2'd0, S_SNOOP = 2'd1, S_WB = 2'd2, S_DONE = 2'd3;

  logic CLK = 1'b0;
  logic nRST = 1'b0;

  // 2-cache instance signals
  logic [1:0]  c2_cctrans = '0, c2_ccwrite = '0, c2_done = '0, c2_dirty = '0, c2_dwait = '0;
  logic [63:0] c2_daddr = '0;
  logic [1:0]  c2_ccwait, c2_ccinv, c2_grant, c2_wb_src, c2_state;
  logic [31:0] c2_addr;
  logic        c2_xfer;
  // 4-cache instance signals
  logic [3:0]   c4_cctrans = '0, c4_ccwrite = '0, c4_done = '0, c4_dirty = '0, c4_dwait = '0;
  logic [127:0] c4_daddr = '0;
  logic [3:0]   c4_ccwait, c4_ccinv, c4_grant, c4_wb_src;
  logic [1:0]   c4_state;
  logic [31:0]  c4_addr;
  logic         c4_xfer;
`ifdef SNOOP_TIMEOUT_EN
  logic c2_err, c4_err;
`endif

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];
  logic [3:0] prev_grant4 = '0;

  snoop_bus_ctrl #(.NCORE(2), .BLK_WORDS(2), .AW(32)) u_dut2 (
    .CLK(CLK), .nRST(nRST), .cctrans(c2_cctrans), .ccwrite(c2_ccwrite), .daddr(c2_daddr),
    .snoop_done(c2_done), .snoop_dirty(c2_dirty), .dwait(c2_dwait), .ccwait(c2_ccwait),
    .ccinv(c2_ccinv), .ccsnoopaddr(c2_addr), .grant(c2_grant), .wb_src(c2_wb_src),
    .xfer_done(c2_xfer),
`ifdef SNOOP_TIMEOUT_EN
    .snoop_err(c2_err),
`endif
    .fsm_state(c2_state));

  snoop_bus_ctrl #(.NCORE(4), .BLK_WORDS(2), .AW(32)) u_dut4 (
    .CLK(CLK), .nRST(nRST), .cctrans(c4_cctrans), .ccwrite(c4_ccwrite), .daddr(c4_daddr),
    .snoop_done(c4_done), .snoop_dirty(c4_dirty), .dwait(c4_dwait), .ccwait(c4_ccwait),
    .ccinv(c4_ccinv), .ccsnoopaddr(c4_addr), .grant(c4_grant), .wb_src(c4_wb_src),
    .xfer_done(c4_xfer),
`ifdef SNOOP_TIMEOUT_EN
    .snoop_err(c4_err),
`endif
    .fsm_state(c4_state));

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  // scoreboard: every new grant on the 4-cache bus must match the queue head
  always @(negedge CLK) begin
    if (c4_grant != 4'b0 && prev_grant4 == 4'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL grant4_unexpected observed=%0h expected=none", c4_grant);
      end else begin
        chk("grant4_order", c4_grant, exp_q.pop_front());
      end
    end
    prev_grant4 = c4_grant;
  end

  initial begin
    int n;
    int cyc;
    logic seen_err;

    // reset state
    #1;
    chk("rst_state", c2_state, S_IDLE);
    chk("rst_grant", c2_grant, 2'b00);
    chk("rst_ccwait", c2_ccwait, 2'b00);
    chk("rst_addr", c2_addr, 32'h0);
    chk("rst_xfer", c2_xfer, 1'b0);
    tick();
    nRST = 1'b1;
    tick();

    // clean read by cache 0
    c2_daddr   = {32'h0000_0200, 32'h0000_0100};
    c2_cctrans = 2'b01;
    c2_ccwrite = 2'b00;
    tick();
    chk("a_state", c2_state, S_SNOOP);
    chk("a_grant", c2_grant, 2'b01);
    chk("a_ccwait", c2_ccwait, 2'b10);
    chk("a_ccinv", c2_ccinv, 2'b00);
    chk("a_addr", c2_addr, 32'h100);
    c2_done = 2'b11;  // owner's own done bit must be ignored
    tick();
    chk("a_state_done", c2_state, S_DONE);
    chk("a_xfer", c2_xfer, 1'b1);
    chk("a_grant_clr", c2_grant, 2'b00);
    chk("a_ccwait_clr", c2_ccwait, 2'b00);
    c2_cctrans = 2'b00;
    c2_done    = 2'b00;
    tick();
    chk("a_xfer_pulse", c2_xfer, 1'b0);
    chk("a_addr_hold", c2_addr, 32'h100);
    chk("a_idle", c2_state, S_IDLE);

    // write by cache 1, cache 0 dirty, stalled write-back
    c2_daddr   = {32'h0000_02C0, 32'h0000_0100};
    c2_cctrans = 2'b10;
    c2_ccwrite = 2'b10;
    tick();
    chk("b_grant", c2_grant, 2'b10);
    chk("b_ccinv", c2_ccinv, 2'b01);
    chk("b_ccwait", c2_ccwait, 2'b01);
    chk("b_addr", c2_addr, 32'h2C0);
    tick();
    chk("b_snoop_wait", c2_state, S_SNOOP);
    c2_done  = 2'b01;
    c2_dirty = 2'b01;
    tick();
    chk("b_wb_src", c2_wb_src, 2'b01);
    chk("b_wb_ccinv", c2_ccinv, 2'b01);
    c2_done  = 2'b00;
    c2_dirty = 2'b00;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b_wb_cycle%0d", i), c2_state, S_WB);
      c2_dwait = (i % 2 == 0) ? 2'b01 : 2'b00;
      tick();
    end
    chk("b_done_state", c2_state, S_DONE);
    chk("b_xfer", c2_xfer, 1'b1);
    chk("b_wb_clr", c2_wb_src, 2'b00);
    chk("b_ccinv_clr", c2_ccinv, 2'b00);
    c2_cctrans = 2'b00;
    c2_ccwrite = 2'b00;
    c2_dwait   = 2'b00;
    tick();

    // round robin among four held requesters
    c4_daddr = {32'h4000, 32'h3000, 32'h2000, 32'h1000};
    c4_done  = 4'b1111;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    c4_cctrans = 4'b1111;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (c4_xfer) n++;
      if (n == 5) begin
        c4_cctrans = 4'b0000;
        break;
      end
    end
    chk("rr_xfer_count", n, 5);
    tick();
    tick();
    chk("rr_queue_empty", exp_q.size(), 0);

    // caches 1 and 3 dirty: lowest index writes back
    exp_q.push_back(4'b0001);
    c4_cctrans = 4'b0001;
    c4_done    = 4'b1110;
    c4_dirty   = 4'b1010;
    tick();
    chk("d_grant", c4_grant, 4'b0001);
    chk("d_ccwait", c4_ccwait, 4'b1110);
    chk("d_addr", c4_addr, 32'h1000);
    tick();
    chk("d_wb_src", c4_wb_src, 4'b0010);
    chk("d_state_wb", c4_state, S_WB);
    c4_done  = 4'b0000;
    c4_dirty = 4'b0000;
    tick();
    chk("d_wb_second", c4_state, S_WB);
    tick();
    chk("d_xfer", c4_xfer, 1'b1);
    c4_cctrans = 4'b0000;
    tick();
    tick();

    // reset in the middle of a write-back
    c2_cctrans = 2'b01;
    c2_done    = 2'b10;
    c2_dirty   = 2'b10;
    c2_dwait   = 2'b10;
    tick();
    tick();
    chk("r_in_wb", c2_state, S_WB);
    #2 nRST = 1'b0;
    #1;
    chk("r_state", c2_state, S_IDLE);
    chk("r_grant", c2_grant, 2'b00);
    chk("r_wb_src", c2_wb_src, 2'b00);
    chk("r_ccwait", c2_ccwait, 2'b00);
    chk("r_ccinv", c2_ccinv, 2'b00);
    chk("r_addr", c2_addr, 32'h0);
    chk("r_xfer", c2_xfer, 1'b0);
    c2_cctrans = 2'b00;
    c2_done    = 2'b00;
    c2_dirty   = 2'b00;
    c2_dwait   = 2'b00;
    tick();
    nRST = 1'b1;
    tick();
    chk("r_no_xfer", c2_xfer, 1'b0);

`ifdef SNOOP_TIMEOUT_EN
    // snoop never answered: timeout closes the transaction
    c2_cctrans = 2'b01;
    cyc = 0;
    seen_err = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (c2_state == S_SNOOP) cyc++;
      if (c2_xfer) begin
        seen_err = c2_err;
        break;
      end
    end
    c2_cctrans = 2'b00;
    chk("t_snoop_cycles", cyc, 255);
    chk("t_snoop_err", seen_err, 1'b1);
    tick();
    chk("t_err_pulse", c2_err, 1'b0);
`else
    cyc = 0;
    seen_err = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
